// File: rtl/shifter_pkg.sv
// Shared constants and elaboration helpers for the pipelined barrel shifter.
// Optional sticky support is selected with the PIPE_SHIFTER_STICKY_EN macro.
package shifter_pkg;

    localparam logic SHIFT_LEFT  = 1'b1;
    localparam logic SHIFT_RIGHT = 1'b0;

    // Level index after which pipeline register j (1..stages) sits.
    function automatic int stage_boundary(input int j, input int ewr, input int stages);
        return (j * ewr + stages - 1) / stages - 1;
    endfunction

    // Register number placed after the given level, or 0 when the level is purely combinational.
    function automatic int stage_index(input int level, input int ewr, input int stages);
        int idx;
        idx = 0;
        for (int j = 1; j <= stages; j++) begin
            if (stage_boundary(j, ewr, stages) == level) idx = j;
        end
        return idx;
    endfunction

    // Stage payload: data, sticky, direction, fill bit and remaining shift amount.
    function automatic int payload_width(input int swr, input int ewr);
        return swr + 3 + ewr;
    endfunction

endpackage

// File: rtl/shifter_mux_level.sv
// One barrel-shifter level: conditionally shifts by 2^LEVEL in either direction.
// With PIPE_SHIFTER_STICKY_EN it also ORs the original data bits dropped by a right shift.
module shifter_mux_level
    import shifter_pkg::*;
#(
    parameter int SWR   = 26,
`ifdef PIPE_SHIFTER_STICKY_EN
    parameter int EWR   = 5,
`endif
    parameter int LEVEL = 0
) (
    input  logic [SWR-1:0] data_in,
    input  logic           sel,
    input  logic           dir,
    input  logic           fill,
`ifdef PIPE_SHIFTER_STICKY_EN
    input  logic [EWR-1:0] done,
    input  logic           sticky_in,
    output logic           sticky_out,
`endif
    output logic [SWR-1:0] data_out
);

    localparam int             SH   = 2 ** LEVEL;
    localparam logic [SWR-1:0] ONES = '1;

    always_comb begin
        data_out = data_in;
        if (sel) begin
            if (dir == SHIFT_LEFT) begin
                data_out = data_in << SH;
            end else begin
                data_out = (data_in >> SH) | (fill ? ~(ONES >> SH) : '0);
            end
        end
    end

`ifdef PIPE_SHIFTER_STICKY_EN
    // Bits at or above SWR-done are fill inserted by earlier levels, not original data.
    assign sticky_out = sticky_in
                      | (sel && (dir == SHIFT_RIGHT)
                         && (|(data_in & ~(ONES << SH) & (ONES >> done))));
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with valid/ready flow control and programmable right-shift fill.
// Define PIPE_SHIFTER_STICKY_EN to build the sticky-bit path and its pipeline flops.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int SWR    = 26,
    parameter int EWR    = 5,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    output logic           ready_o,
    input  logic [EWR-1:0] Shift_Value_i,
    input  logic [SWR-1:0] Shift_Data_i,
    input  logic           Left_Right_i,
    input  logic           Bit_Shift_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [SWR-1:0] N_mant_o,
    output logic           Sticky_o
);

    // Handshake: an item moves on a rising edge when valid and ready are both high.
    // The whole pipe advances together; it holds when the output is valid and not taken.
    logic adv;
    assign adv     = !valid_o || ready_i;
    assign ready_o = adv;

    for (genvar k = 0; k < EWR; k++) begin : g_lvl
        localparam int REG_IDX  = stage_index(k, EWR, STAGES);
        localparam int PREV_IDX = (k == 0) ? 0 : stage_index(k - 1, EWR, STAGES);

        logic [SWR-1:0]   d_in;
        logic [SWR-1:0]   d_out;
        logic             dir;
        logic             fill;
        logic             v_in;
        logic [EWR-1-k:0] rem;
`ifdef PIPE_SHIFTER_STICKY_EN
        logic [EWR-1:0]   done;
        logic             s_in;
        logic             s_out;
`endif

        if (k == 0) begin : g_src
            assign d_in = Shift_Data_i;
            assign dir  = Left_Right_i;
            assign fill = Bit_Shift_i;
            assign rem  = Shift_Value_i;
            assign v_in = load_i;
`ifdef PIPE_SHIFTER_STICKY_EN
            assign done = '0;
            assign s_in = 1'b0;
`endif
        end else if (PREV_IDX != 0) begin : g_from_reg
            assign d_in = g_lvl[k-1].g_reg.data_q;
            assign dir  = g_lvl[k-1].g_reg.g_fwd.dir_q;
            assign fill = g_lvl[k-1].g_reg.g_fwd.fill_q;
            assign rem  = g_lvl[k-1].g_reg.g_fwd.rem_q;
            assign v_in = g_lvl[k-1].g_reg.v_q;
`ifdef PIPE_SHIFTER_STICKY_EN
            assign done = g_lvl[k-1].g_reg.g_fwd.done_q;
            assign s_in = g_lvl[k-1].g_reg.sticky_q;
`endif
        end else begin : g_from_comb
            assign d_in = g_lvl[k-1].d_out;
            assign dir  = g_lvl[k-1].dir;
            assign fill = g_lvl[k-1].fill;
            assign rem  = g_lvl[k-1].rem[EWR-k:1];
            assign v_in = g_lvl[k-1].v_in;
`ifdef PIPE_SHIFTER_STICKY_EN
            assign done = g_lvl[k-1].done | (EWR'(g_lvl[k-1].rem[0]) << (k - 1));
            assign s_in = g_lvl[k-1].s_out;
`endif
        end

        shifter_mux_level #(
            .SWR   (SWR),
`ifdef PIPE_SHIFTER_STICKY_EN
            .EWR   (EWR),
`endif
            .LEVEL (k)
        ) u_mux (
            .data_in    (d_in),
            .sel        (rem[0]),
            .dir        (dir),
            .fill       (fill),
`ifdef PIPE_SHIFTER_STICKY_EN
            .done       (done),
            .sticky_in  (s_in),
            .sticky_out (s_out),
`endif
            .data_out   (d_out)
        );

        if (REG_IDX != 0) begin : g_reg
            logic [SWR-1:0] data_q;
            logic           v_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_q <= '0;
                    v_q    <= 1'b0;
                end else if (adv) begin
                    data_q <= d_out;
                    v_q    <= v_in;
                end
            end

`ifdef PIPE_SHIFTER_STICKY_EN
            logic sticky_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)     sticky_q <= 1'b0;
                else if (adv) sticky_q <= s_out;
            end
`endif

            // Control fields only travel on to later levels; the last register carries results.
            if (k < EWR - 1) begin : g_fwd
                logic             dir_q;
                logic             fill_q;
                logic [EWR-2-k:0] rem_q;
`ifdef PIPE_SHIFTER_STICKY_EN
                logic [EWR-1:0]   done_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst)     done_q <= '0;
                    else if (adv) done_q <= done | (EWR'(rem[0]) << k);
                end
`endif
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        dir_q  <= 1'b0;
                        fill_q <= 1'b0;
                        rem_q  <= '0;
                    end else if (adv) begin
                        dir_q  <= dir;
                        fill_q <= fill;
                        rem_q  <= rem[EWR-1-k:1];
                    end
                end
            end
        end
    end

    assign valid_o  = g_lvl[EWR-1].g_reg.v_q;
    assign N_mant_o = g_lvl[EWR-1].g_reg.data_q;
`ifdef PIPE_SHIFTER_STICKY_EN
    assign Sticky_o = g_lvl[EWR-1].g_reg.sticky_q;
`else
    assign Sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter: directed cases, stall, reset, sweep and random traffic.
// Expected sticky values are forced to 0 when PIPE_SHIFTER_STICKY_EN is not defined.
module tb_pipelined_barrel_shifter;

    localparam int SWR    = 26;
    localparam int EWR    = 5;
    localparam int STAGES = 2;
`ifdef PIPE_SHIFTER_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           load_i;
    logic           ready_o;
    logic [EWR-1:0] shift_value;
    logic [SWR-1:0] shift_data;
    logic           left_right;
    logic           bit_shift;
    logic           valid_o;
    logic           ready_i;
    logic [SWR-1:0] n_mant;
    logic           sticky;

    int             checks   = 0;
    int             failures = 0;
    int             out_count = 0;
    logic [SWR:0]   exp_q[$];
    logic [SWR:0]   sb_exp;
    bit             bp_on;

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog observed=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    pipelined_barrel_shifter #(
        .SWR    (SWR),
        .EWR    (EWR),
        .STAGES (STAGES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_i        (load_i),
        .ready_o       (ready_o),
        .Shift_Value_i (shift_value),
        .Shift_Data_i  (shift_data),
        .Left_Right_i  (left_right),
        .Bit_Shift_i   (bit_shift),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .N_mant_o      (n_mant),
        .Sticky_o      (sticky)
    );

    // Reference model: bit-by-bit definition of the shift, returns {sticky, data}.
    function automatic logic [SWR:0] ref_model(input logic [SWR-1:0] d, input int s,
                                               input logic left, input logic fill);
        logic [SWR-1:0] n;
        logic           st;
        n  = '0;
        st = 1'b0;
        for (int i = 0; i < SWR; i++) begin
            if (left) begin
                if (i >= s) n[i] = d[i-s];
                else        n[i] = 1'b0;
            end else begin
                if (i + s < SWR) n[i] = d[i+s];
                else             n[i] = fill;
                if (i < s)       st = st | d[i];
            end
        end
        if (!STICKY_ON) st = 1'b0;
        return {st, n};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: record accepts and compare every delivered item at the negative edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (load_i && ready_o)
                exp_q.push_back(ref_model(shift_data, int'(shift_value), left_right, bit_shift));
            if (valid_o && ready_i) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", valid_o, 1'b0);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("sb_data", n_mant, sb_exp[SWR-1:0]);
                    check("sb_sticky", sticky, sb_exp[SWR]);
                end
            end
        end
    end

    // Driver: present one item and hold it until the DUT accepts it.
    task automatic send(input logic [SWR-1:0] d, input logic [EWR-1:0] s,
                        input logic left, input logic fill);
        bit got;
        int n;
        shift_data  = d;
        shift_value = s;
        left_right  = left;
        bit_shift   = fill;
        load_i      = 1'b1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) check("send_timeout", ready_o, 1'b1);
    endtask

    task automatic directed(input string tag, input logic [SWR-1:0] d, input logic [EWR-1:0] s,
                            input logic left, input logic fill,
                            input logic [SWR-1:0] exp_n, input logic exp_st);
        int n;
        send(d, s, left, fill);
        load_i = 1'b0;
        n = 1;
        while (!valid_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, n, STAGES);
        check({tag, "_data"}, n_mant, exp_n);
        check({tag, "_sticky"}, sticky, STICKY_ON ? exp_st : 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_o) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        logic [SWR-1:0] d1, d2, d3, d4;
        logic [SWR:0]   e1;
        int             c0;

        rst         = 1'b0;
        load_i      = 1'b0;
        ready_i     = 1'b1;
        shift_value = '0;
        shift_data  = '0;
        left_right  = 1'b0;
        bit_shift   = 1'b0;
        bp_on       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", valid_o, 1'b0);
        check("rst_data", n_mant, '0);
        check("rst_sticky", sticky, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        directed("r4_ones",  26'h3FFFFFF, 5'd4,  1'b0, 1'b0, 26'h03FFFFF, 1'b1);
        directed("r4_bit4",  26'h0000010, 5'd4,  1'b0, 1'b0, 26'h0000001, 1'b0);
        directed("l25",      26'h0000001, 5'd25, 1'b1, 1'b0, 26'h2000000, 1'b0);
        directed("l0",       26'h1555555, 5'd0,  1'b1, 1'b0, 26'h1555555, 1'b0);
        directed("r31_sat",  26'h0000001, 5'd31, 1'b0, 1'b1, 26'h3FFFFFF, 1'b1);
        directed("l31_sat",  26'h3FFFFFF, 5'd31, 1'b1, 1'b1, 26'h0000000, 1'b0);
        directed("r26_sat",  26'h2000001, 5'd26, 1'b0, 1'b0, 26'h0000000, 1'b1);
        directed("r0",       26'h2AAAAAA, 5'd0,  1'b0, 1'b1, 26'h2AAAAAA, 1'b0);
        directed("l5",       26'h3FFFFFF, 5'd5,  1'b1, 1'b1, 26'h3FFFFE0, 1'b0);
        directed("r3_fill1", 26'h0000008, 5'd3,  1'b0, 1'b1, 26'h3800001, 1'b0);
        drain("drain_directed");

        // Back-to-back with a three-cycle output stall
        d1 = 26'($urandom);
        d2 = 26'($urandom);
        d3 = 26'($urandom);
        d4 = 26'($urandom);
        e1 = ref_model(d1, 7, 1'b0, 1'b1);
        c0 = out_count;
        send(d1, 5'd7, 1'b0, 1'b1);
        send(d2, 5'd3, 1'b1, 1'b0);
        ready_i     = 1'b0;
        shift_data  = d3;
        shift_value = 5'd12;
        left_right  = 1'b0;
        bit_shift   = 1'b0;
        #1;
        check("stall_ready0", ready_o, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_ready", ready_o, 1'b0);
            check("stall_valid", valid_o, 1'b1);
            check("stall_hold_data", n_mant, e1[SWR-1:0]);
        end
        ready_i = 1'b1;
        send(d3, 5'd12, 1'b0, 1'b0);
        send(d4, 5'd20, 1'b1, 1'b0);
        load_i = 1'b0;
        drain("drain_stall");
        check("stall_out_count", out_count - c0, 4);

        // Reset with two items in flight
        c0 = out_count;
        send(26'h1234567, 5'd1, 1'b0, 1'b0);
        send(26'h0ABCDEF, 5'd2, 1'b1, 1'b0);
        load_i = 1'b0;
        check("pre_reset_valid", valid_o, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_reset_valid", valid_o, 1'b0);
        check("mid_reset_data", n_mant, '0);
        check("mid_reset_ready", ready_o, 1'b1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_reset_valid", valid_o, 1'b0);
        check("post_reset_outs", out_count - c0, 0);

        // Sweep every shift amount in both directions
        for (int dir = 0; dir < 2; dir++) begin
            for (int s = 0; s < 32; s++) begin
                send(26'($urandom), 5'(s), 1'(dir), 1'($urandom_range(0, 1)));
            end
        end
        load_i = 1'b0;
        drain("drain_sweep");

        // Random traffic with random backpressure and idle gaps
        c0 = out_count;
        bp_on = 1'b1;
        fork
            begin
                while (bp_on) begin
                    @(posedge clk);
                    #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                repeat (40) begin
                    send(26'($urandom), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        load_i = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                load_i = 1'b0;
                bp_on  = 1'b0;
            end
        join
        ready_i = 1'b1;
        drain("drain_random");
        check("random_out_count", out_count - c0, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
